score_display_scan: RTL and testbench
=====================================

SCORE_DISPLAY_SCAN -- requirements
Module: score_display_scan

Interface
REQ-001 Parameter SCAN_DIV, 50000, clocks per digit slot; legal range >= 2.
REQ-002 Parameter FLASH_FRAMES, 8, frames of change-flash (used only with SCORE_FLASH_EN); legal range 1..255.
REQ-003 clk  input  1  system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 n3  input  4  BCD thousands digit from the score splitter.
REQ-006 n2  input  4  BCD hundreds digit.
REQ-007 n1  input  4  BCD tens digit.
REQ-008 n0  input  4  BCD units digit.
REQ-009 seg  output  7  segment drive, active-high, seg[0]=a .. seg[6]=g, registered.
REQ-010 an  output  4  digit enable, one-hot or zero, active-high, an[k] selects digit nk, registered.

Function
REQ-011 Prescaler SHALL count 0..SCAN_DIV-1 and wrap; the clock where it equals SCAN_DIV-1 is a "tick".
REQ-012 Slot index idx (2 bits) SHALL advance 0->1->2->3->0 on each tick; idx 0 maps to n0, idx 3 to n3.
REQ-013 On a tick with idx==3 (frame boundary), shadow digits SHALL latch n3..n0; inputs SHALL have no effect on outputs at any other time (no mid-frame tearing).
REQ-014 an and seg SHALL be recomputed every clock from the current idx and shadow; output latency is exactly one clock after idx/shadow change.
REQ-015 Encoding: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-016 Shadow digit value 10..15 SHALL display a dash (seg=0x40), and counts as nonzero for blanking.
REQ-017 Leading-zero blanking: slot 3 blank if s3==0; slot 2 blank if s3==s2==0; slot 1 blank if s3==s2==s1==0; slot 0 never blank.
REQ-018 Blank slot SHALL drive an=4'b0000 and seg=7'h00 for its whole slot duration.
REQ-019 Non-blank slot SHALL drive an with exactly bit idx set and seg per REQ-015/016.
REQ-020 Each slot SHALL last exactly SCAN_DIV clocks; one frame lasts 4*SCAN_DIV clocks.

Reset
REQ-021 While rst==0: prescaler=0, idx=0, shadow=0, flash counter=0, an=4'b0000, seg=7'h00, asynchronously.
REQ-022 After rst release, shadow stays 0 until the first frame boundary; first displayed slot is digit 0 showing 0x3F from the first clock edge after release.
REQ-023 rst asserted mid-frame SHALL abort the frame; the partially latched state is discarded.

Configuration
REQ-024 Macro SCORE_FLASH_EN defined: at a frame boundary where latched inputs differ from current shadow, flash counter SHALL load FLASH_FRAMES; at other frame boundaries a nonzero counter SHALL decrement by 1; a new change reloads it.
REQ-025 With SCORE_FLASH_EN, while flash counter is odd, all slots SHALL be blank (an=0, seg=0); even or zero counter displays normally.
REQ-026 Without SCORE_FLASH_EN, no flash counter exists, FLASH_FRAMES is ignored, display never flashes.

Verification
REQ-027 SCAN_DIV=4, inputs 0,0,0,0 after reset -> an=0001/seg=0x3F in slot 0, an=0000/seg=0x00 in slots 1..3, repeating every 16 clocks.
REQ-028 SCAN_DIV=4, n3..n0=1,2,3,4 -> slots 0..3 show an=0001/0x66, 0010/0x4F, 0100/0x5B, 1000/0x06, each 4 clocks.
REQ-029 n3..n0=0,0,5,0 -> slots 3,2 blank, slot 1 0x6D, slot 0 0x3F; n1 forced to 4'hC -> slot 1 seg=0x40.
REQ-030 Change inputs 1,2,3,4 -> 9,9,9,9 during slot 1 -> outputs unchanged until after next frame boundary, then all slots 0x6F.
REQ-031 SCORE_FLASH_EN, FLASH_FRAMES=4, input change -> frames show, blank, show, blank, then normal; second change during flash restarts sequence.
REQ-032 rst pulsed low mid-slot 2 -> an=0, seg=0 immediately, no clock required; after release slot 0 resumes with prescaler from 0.

Source files
------------

// File: rtl/score_display_scan_if.sv
// score_display_scan_if: BCD digit inputs and segment/anode outputs of the scanner
interface score_display_scan_if;
  logic [3:0] n3;
  logic [3:0] n2;
  logic [3:0] n1;
  logic [3:0] n0;
  logic [6:0] seg;
  logic [3:0] an;
  modport master (output n3, n2, n1, n0, input seg, an);
  modport slave (input n3, n2, n1, n0, output seg, an);
endinterface

// File: rtl/score_display_scan.sv
// score_display_scan: 4-digit multiplexed 7-segment scanner with frame-latched shadow and leading-zero blanking; define SCORE_FLASH_EN for change-flash
module score_display_scan #(
  parameter int SCAN_DIV = 50000,
  parameter int FLASH_FRAMES = 8
) (
  input logic clk,
  input logic rst,
  score_display_scan_if.slave bus
);
  localparam int CW = $clog2(SCAN_DIV);
  if (SCAN_DIV < 2 || FLASH_FRAMES < 1 || FLASH_FRAMES > 255) begin : g_bad_param
    $error("score_display_scan: parameter out of range");
  end
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [3:0] s3, s2, s1, s0;
  logic tick, frame, hide, blank;
  logic [3:0] d;
  logic [6:0] enc;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  assign frame = tick && idx == 2'd3;
  // prescaler and slot index
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      idx <= 2'd0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      idx <= tick ? idx + 2'd1 : idx;
    end
  // shadow digits only change at a frame boundary so a frame never tears
  always_ff @(posedge clk or negedge rst)
    if (!rst) {s3, s2, s1, s0} <= '0;
    else if (frame) {s3, s2, s1, s0} <= {bus.n3, bus.n2, bus.n1, bus.n0};
`ifdef SCORE_FLASH_EN
  logic [7:0] fc;
  // flash counter reloads on a changed score, otherwise counts frames down to zero
  always_ff @(posedge clk or negedge rst)
    if (!rst) fc <= 8'd0;
    else if (frame)
      fc <= ({bus.n3, bus.n2, bus.n1, bus.n0} != {s3, s2, s1, s0}) ? 8'(FLASH_FRAMES) :
            (fc != 8'd0) ? fc - 8'd1 : fc;
  assign hide = fc[0];
`else
  assign hide = 1'b0;
`endif
  // select the current digit, encode it and decide blanking
  always_comb begin
    d = idx == 2'd3 ? s3 : idx == 2'd2 ? s2 : idx == 2'd1 ? s1 : s0;
    case (d)
      4'd0: enc = 7'h3F;
      4'd1: enc = 7'h06;
      4'd2: enc = 7'h5B;
      4'd3: enc = 7'h4F;
      4'd4: enc = 7'h66;
      4'd5: enc = 7'h6D;
      4'd6: enc = 7'h7D;
      4'd7: enc = 7'h07;
      4'd8: enc = 7'h7F;
      4'd9: enc = 7'h6F;
      default: enc = 7'h40;
    endcase
    blank = hide
          || (idx == 2'd3 && s3 == 4'd0)
          || (idx == 2'd2 && s3 == 4'd0 && s2 == 4'd0)
          || (idx == 2'd1 && s3 == 4'd0 && s2 == 4'd0 && s1 == 4'd0);
  end
  // registered drive: one clock after idx/shadow
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.an <= 4'b0000;
      bus.seg <= 7'h00;
    end else begin
      bus.an <= blank ? 4'b0000 : 4'b0001 << idx;
      bus.seg <= blank ? 7'h00 : enc;
    end
endmodule

// File: tb/tb_score_display_scan.sv
// tb_score_display_scan: scoreboard bench for score_display_scan with a spec-level scan model
module tb_score_display_scan;
  localparam int DIV = 4;
  localparam int FF = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  score_display_scan_if bus ();
  score_display_scan #(.SCAN_DIV(DIV), .FLASH_FRAMES(FF)) dut (.clk(clk), .rst(rst), .bus(bus));
  int n_vec = 0;
  int n_bad = 0;
  int m_cnt;
  int m_fc;
  logic [1:0] m_idx;
  logic [3:0] ms [4];
  logic [10:0] q [$];
  function automatic logic [6:0] enc(input logic [3:0] v);
    case (v)
      4'd0: return 7'h3F;
      4'd1: return 7'h06;
      4'd2: return 7'h5B;
      4'd3: return 7'h4F;
      4'd4: return 7'h66;
      4'd5: return 7'h6D;
      4'd6: return 7'h7D;
      4'd7: return 7'h07;
      4'd8: return 7'h7F;
      4'd9: return 7'h6F;
      default: return 7'h40;
    endcase
  endfunction
  function automatic logic [10:0] model_out();
    logic bl;
    bl = m_fc % 2 == 1;
    for (int k = 3; k > 0; k--) begin
      logic z;
      z = 1'b1;
      for (int j = 3; j >= k; j--) z = z && ms[j] == 4'd0;
      if (m_idx == 2'(k) && z) bl = 1'b1;
    end
    return bl ? 11'h000 : {4'b0001 << m_idx, enc(ms[m_idx])};
  endfunction
  task automatic model_reset();
    m_cnt = 0;
    m_idx = 2'd0;
    m_fc = 0;
    for (int k = 0; k < 4; k++) ms[k] = 4'd0;
  endtask
  task automatic model_step();
    logic [3:0] nw [4];
    logic tk;
    tk = m_cnt == DIV - 1;
    if (tk && m_idx == 2'd3) begin
      nw = '{bus.n0, bus.n1, bus.n2, bus.n3};
`ifdef SCORE_FLASH_EN
      if (nw != ms) m_fc = FF;
      else if (m_fc != 0) m_fc--;
`endif
      ms = nw;
    end
    if (tk) m_idx = m_idx + 2'd1;
    m_cnt = tk ? 0 : m_cnt + 1;
  endtask
  task automatic check(input string tag, input logic [10:0] obs, input logic [10:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed an/seg=%b/%h expected an/seg=%b/%h", tag, obs[10:7], obs[6:0], exp[10:7], exp[6:0]);
    end
  endtask
  task automatic cycle(input string tag);
    q.push_back(rst ? model_out() : 11'h000);
    @(posedge clk);
    if (!rst) model_reset();
    else model_step();
    #1;
    check(tag, {bus.an, bus.seg}, q.pop_front());
  endtask
  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask
  task automatic set_n(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
    bus.n3 = a;
    bus.n2 = b;
    bus.n1 = c;
    bus.n0 = e;
  endtask
  initial begin
    model_reset();
    set_n(4'd0, 4'd0, 4'd0, 4'd0);
    #1;
    check("reset_async", {bus.an, bus.seg}, 11'h000);
    run("reset_hold", 2);
    rst = 1'b1;
    run("zeros", 2 * 4 * DIV);
    set_n(4'd1, 4'd2, 4'd3, 4'd4);
    run("digits_1234", 3 * 4 * DIV);
    set_n(4'd0, 4'd0, 4'd5, 4'd0);
    run("blank_0050", 2 * 4 * DIV);
    bus.n1 = 4'hC;
    run("dash", 2 * 4 * DIV);
    set_n(4'd1, 4'd2, 4'd3, 4'd4);
    run("back_1234", 2 * 4 * DIV);
    while (m_idx != 2'd1) cycle("seek_slot1");
    cycle("in_slot1");
    set_n(4'd9, 4'd9, 4'd9, 4'd9);
    run("no_tear_9999", 3 * 4 * DIV);
`ifdef SCORE_FLASH_EN
    set_n(4'd3, 4'd3, 4'd3, 4'd3);
    run("flash_a", 6 * 4 * DIV);
    set_n(4'd2, 4'd0, 4'd2, 4'd0);
    run("flash_b", 5 * 4 * DIV);
`endif
    while (m_idx != 2'd2) cycle("seek_slot2");
    cycle("in_slot2");
    rst = 1'b0;
    #1;
    check("reset_mid_an", {7'd0, bus.an}, 11'h000);
    check("reset_mid_seg", {4'd0, bus.seg}, 11'h000);
    run("reset_mid_hold", 2);
    rst = 1'b1;
    run("after_reset", 2 * 4 * DIV);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
